// File: rtl/redundancy_scheduler_if.sv
// Table write port: the scheduler (master) presents one granted lane entry per wr_en pulse.
interface redundancy_scheduler_if #(
    parameter int NUM_LANES  = 4,
    parameter int ITER_WIDTH = 9,
    parameter int STEP_RANGE = 128
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic                  wr_ready;
    logic                  wr_en;
    logic [LW-1:0]         wr_lane;
    logic [ITER_WIDTH-1:0] wr_ch_it;
    logic [ITER_WIDTH-1:0] wr_src_it;
    logic [ITER_WIDTH-1:0] wr_dest_it;
    logic [STEP_RANGE-1:0] wr_src_mt;
    logic [1:0]            wr_src_st;
    logic [1:0]            wr_dest_st;

    modport master (
        input  wr_ready,
        output wr_en, wr_lane, wr_ch_it, wr_src_it, wr_dest_it, wr_src_mt, wr_src_st, wr_dest_st
    );
    modport slave (
        output wr_ready,
        input  wr_en, wr_lane, wr_ch_it, wr_src_it, wr_dest_it, wr_src_mt, wr_src_st, wr_dest_st
    );
endinterface

// File: rtl/redundancy_scheduler.sv
// Sequences a set of redundancy-checker lanes through clear/launch/run/flush and
// arbitrates their results round-robin onto a single table write port.
module redundancy_scheduler_lane (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic run,
    input  logic masked,
    input  logic grant,
    input  logic valid,
    input  logic done,
    output logic req,
    output logic en_wt,
    output logic fin_nxt
);
    logic ack1, ack2, fin;

    // ack1/ack2 form the two-cycle window after a grant; only ack1 drops the write enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack1 <= 1'b0;
            ack2 <= 1'b0;
            fin  <= 1'b0;
        end else if (clr) begin
            ack1 <= 1'b0;
            ack2 <= 1'b0;
            fin  <= 1'b0;
        end else begin
            ack1 <= grant;
            ack2 <= ack1;
            fin  <= fin_nxt;
        end
    end

    assign req     = run & masked & valid & ~ack1 & ~ack2;
    assign en_wt   = run & masked & ~ack1;
    assign fin_nxt = fin | (run & masked & done);
endmodule

module redundancy_scheduler #(
    parameter int NUM_LANES  = 4,
    parameter int ITER_WIDTH = 9,
    parameter int STEP_RANGE = 128,
    parameter int TMO_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [NUM_LANES-1:0]             lane_mask,
    input  logic [TMO_WIDTH-1:0]             tmo_limit,
    output logic                             busy,
    output logic                             job_done,
    output logic                             job_err,
    output logic [NUM_LANES-1:0]             lane_set_idle,
    output logic [NUM_LANES-1:0]             lane_enable_rd,
    output logic [NUM_LANES-1:0]             lane_enable_wt,
    output logic [NUM_LANES-1:0]             lane_enable_fl,
    input  logic [NUM_LANES-1:0]             lane_valid,
    input  logic [NUM_LANES-1:0]             lane_done,
    input  logic [NUM_LANES*ITER_WIDTH-1:0]  lane_ch_it,
    input  logic [NUM_LANES*ITER_WIDTH-1:0]  lane_src_it,
    input  logic [NUM_LANES*ITER_WIDTH-1:0]  lane_dest_it,
    input  logic [NUM_LANES*STEP_RANGE-1:0]  lane_src_mt,
    input  logic [NUM_LANES*2-1:0]           lane_src_st,
    input  logic [NUM_LANES*2-1:0]           lane_dest_st,
    redundancy_scheduler_if.master           wr
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LAUNCH, S_RUN, S_FLUSH, S_DONE, S_ERR} state_t;

    state_t               state, nxt;
    logic [NUM_LANES-1:0] mask_q, req, en_wt, fin_nxt, gnt_vec;
    logic [TMO_WIDTH-1:0] tmo_q, run_cnt;
    logic [LW-1:0]        last_grant, gnt_idx;
    logic                 gnt_vld, gnt, start_acc, run, all_fin, tmo_hit;
    int                   idx;

    assign start_acc = (state == S_IDLE) && start && (lane_mask != '0);
    assign run       = (state == S_RUN);
    assign all_fin   = &(fin_nxt | ~mask_q);
    assign tmo_hit   = run && (tmo_q != '0) && (run_cnt == tmo_q);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign gnt_vec[g] = gnt && (gnt_idx == LW'(g));
        redundancy_scheduler_lane u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (start_acc),
            .run     (run),
            .masked  (mask_q[g]),
            .grant   (gnt_vec[g]),
            .valid   (lane_valid[g]),
            .done    (lane_done[g]),
            .req     (req[g]),
            .en_wt   (en_wt[g]),
            .fin_nxt (fin_nxt[g])
        );
    end

    // Round-robin search beginning just after the last granted lane
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            idx = (int'(last_grant) + k) % NUM_LANES;
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = LW'(idx);
            end
        end
    end

    // No grant may be issued in a cycle that is heading into ERR
    assign gnt = run && wr.wr_ready && gnt_vld && (nxt != S_ERR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (state != S_IDLE && abort) begin
            nxt = S_ERR;
        end else begin
            case (state)
                S_IDLE:   if (start_acc) nxt = S_CLEAR;
                S_CLEAR:  nxt = S_LAUNCH;
                S_LAUNCH: nxt = S_RUN;
                S_RUN:    if (all_fin) nxt = S_FLUSH;
                          else if (tmo_hit) nxt = S_ERR;
                S_FLUSH:  nxt = S_DONE;
                S_DONE:   nxt = S_IDLE;
                S_ERR:    nxt = S_IDLE;
                default:  nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy           = (state != S_IDLE);
        job_done       = (state == S_DONE);
        lane_set_idle  = (state == S_CLEAR || state == S_ERR) ? mask_q : '0;
        lane_enable_rd = (state == S_LAUNCH) ? mask_q : '0;
        lane_enable_fl = (state == S_FLUSH) ? mask_q : '0;
        lane_enable_wt = en_wt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            tmo_q      <= '0;
            run_cnt    <= '0;
            job_err    <= 1'b0;
            last_grant <= LW'(NUM_LANES - 1);
        end else begin
            if (start_acc) begin
                mask_q <= lane_mask;
                tmo_q  <= tmo_limit;
            end
            if (start_acc)         job_err <= 1'b0;
            else if (nxt == S_ERR) job_err <= 1'b1;
            // run_cnt equals the 1-based index of the current RUN cycle, saturating
            if (state == S_LAUNCH)           run_cnt <= TMO_WIDTH'(1);
            else if (run && run_cnt != '1)   run_cnt <= run_cnt + TMO_WIDTH'(1);
            if (gnt) last_grant <= gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr.wr_en      <= 1'b0;
            wr.wr_lane    <= '0;
            wr.wr_ch_it   <= '0;
            wr.wr_src_it  <= '0;
            wr.wr_dest_it <= '0;
            wr.wr_src_mt  <= '0;
            wr.wr_src_st  <= '0;
            wr.wr_dest_st <= '0;
        end else begin
            wr.wr_en <= gnt;
            if (gnt) begin
                wr.wr_lane    <= gnt_idx;
                wr.wr_ch_it   <= lane_ch_it[gnt_idx*ITER_WIDTH +: ITER_WIDTH];
                wr.wr_src_it  <= lane_src_it[gnt_idx*ITER_WIDTH +: ITER_WIDTH];
                wr.wr_dest_it <= lane_dest_it[gnt_idx*ITER_WIDTH +: ITER_WIDTH];
                wr.wr_src_mt  <= lane_src_mt[gnt_idx*STEP_RANGE +: STEP_RANGE];
                wr.wr_src_st  <= lane_src_st[gnt_idx*2 +: 2];
                wr.wr_dest_st <= lane_dest_st[gnt_idx*2 +: 2];
            end
        end
    end
endmodule

// File: tb/tb_redundancy_scheduler.sv
// Directed scenarios; expected output events are queued by the stimulus and
// checked by an independent monitor as the DUT presents them.
module tb_redundancy_scheduler;
    localparam int NL = 4, IW = 9, SR = 128, TW = 16;
    localparam int K_SI = 0, K_RD = 1, K_WR = 2, K_FL = 3, K_DN = 4;

    typedef struct {
        int            kind;
        int            lane;
        int            seq;
        logic [NL-1:0] mask;
    } exp_t;

    logic              clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [NL-1:0]     lane_mask = '0;
    logic [TW-1:0]     tmo_limit = '0;
    logic              busy, job_done, job_err;
    logic [NL-1:0]     lane_set_idle, lane_enable_rd, lane_enable_wt, lane_enable_fl;
    logic [NL-1:0]     lane_valid = '0, lane_done = '0;
    logic [NL*IW-1:0]  lane_ch_it = '0, lane_src_it = '0, lane_dest_it = '0;
    logic [NL*SR-1:0]  lane_src_mt = '0;
    logic [NL*2-1:0]   lane_src_st = '0, lane_dest_st = '0;

    exp_t exp_q[$];
    int   total = 0, bad = 0;
    int   rem[NL], seq[NL];
    bit   want_done[NL];

    redundancy_scheduler_if #(.NUM_LANES(NL), .ITER_WIDTH(IW), .STEP_RANGE(SR)) wr_if ();

    redundancy_scheduler #(.NUM_LANES(NL), .ITER_WIDTH(IW), .STEP_RANGE(SR), .TMO_WIDTH(TW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .lane_mask(lane_mask), .tmo_limit(tmo_limit),
        .busy(busy), .job_done(job_done), .job_err(job_err),
        .lane_set_idle(lane_set_idle), .lane_enable_rd(lane_enable_rd),
        .lane_enable_wt(lane_enable_wt), .lane_enable_fl(lane_enable_fl),
        .lane_valid(lane_valid), .lane_done(lane_done),
        .lane_ch_it(lane_ch_it), .lane_src_it(lane_src_it), .lane_dest_it(lane_dest_it),
        .lane_src_mt(lane_src_mt), .lane_src_st(lane_src_st), .lane_dest_st(lane_dest_st),
        .wr(wr_if)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] f_ch(input int l, input int s);
        return IW'(l * 32 + s + 1);
    endfunction
    function automatic logic [IW-1:0] f_src(input int l, input int s);
        return IW'(l * 32 + s + 101);
    endfunction
    function automatic logic [IW-1:0] f_dst(input int l, input int s);
        return IW'(l * 32 + s + 201);
    endfunction
    function automatic logic [SR-1:0] f_mt(input int l, input int s);
        logic [SR-1:0] v;
        v = '0;
        v[SR-1 -: 8] = 8'(l + 1);
        v[15:0]      = 16'(s * 7 + 3);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic push(input int kind, input int lane, input int s, input logic [NL-1:0] m);
        exp_t e;
        e.kind = kind; e.lane = lane; e.seq = s; e.mask = m;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input int kind, input int lane, input logic [NL-1:0] m);
        exp_t e;
        logic ok;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d lane=%0d mask=%b, required no event", kind, lane, m);
            return;
        end
        e  = exp_q.pop_front();
        ok = (e.kind == kind);
        if (ok && kind == K_WR)
            ok = (e.lane == lane) && (wr_if.wr_ch_it == f_ch(e.lane, e.seq)) &&
                 (wr_if.wr_src_it == f_src(e.lane, e.seq)) && (wr_if.wr_dest_it == f_dst(e.lane, e.seq)) &&
                 (wr_if.wr_src_mt == f_mt(e.lane, e.seq)) && (wr_if.wr_src_st == 2'(e.seq)) &&
                 (wr_if.wr_dest_st == 2'(e.lane + 1)) && (lane_enable_wt[lane] == 1'b0);
        else if (ok)
            ok = (e.mask == m);
        if (!ok) begin
            bad++;
            $display("FAIL event: got kind=%0d lane=%0d mask=%b ch=%0d wt=%b, required kind=%0d lane=%0d mask=%b ch=%0d wt_bit=0",
                     kind, lane, m, wr_if.wr_ch_it, lane_enable_wt, e.kind, e.lane, e.mask, f_ch(e.lane, e.seq));
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (lane_set_idle != '0)  pop_chk(K_SI, 0, lane_set_idle);
            if (lane_enable_rd != '0) pop_chk(K_RD, 0, lane_enable_rd);
            if (wr_if.wr_en)          pop_chk(K_WR, int'(wr_if.wr_lane), '0);
            if (lane_enable_fl != '0) pop_chk(K_FL, 0, lane_enable_fl);
            if (job_done)             pop_chk(K_DN, 0, '0);
        end
    end

    task automatic drive_lanes();
        for (int i = 0; i < NL; i++) begin
            lane_valid[i]            = rem[i] > 0;
            lane_done[i]             = want_done[i] && rem[i] == 0;
            lane_ch_it[i*IW +: IW]   = f_ch(i, seq[i]);
            lane_src_it[i*IW +: IW]  = f_src(i, seq[i]);
            lane_dest_it[i*IW +: IW] = f_dst(i, seq[i]);
            lane_src_mt[i*SR +: SR]  = f_mt(i, seq[i]);
            lane_src_st[i*2 +: 2]    = 2'(seq[i]);
            lane_dest_st[i*2 +: 2]   = 2'(i + 1);
        end
    endtask

    // Advance to the next falling edge; lanes pop an item when their write appears
    task automatic tick();
        @(negedge clk);
        if (wr_if.wr_en && reset_n) begin
            rem[wr_if.wr_lane]--;
            seq[wr_if.wr_lane]++;
        end
        drive_lanes();
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < NL; i++) begin
            rem[i] = 0; seq[i] = 0; want_done[i] = 1'b0;
        end
        drive_lanes();
    endtask

    task automatic load(input int l, input int n, input bit d);
        rem[l] = n; seq[l] = 0; want_done[l] = d;
        drive_lanes();
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctl"}, 32'({busy, job_done, job_err, wr_if.wr_en, lane_set_idle,
                                 lane_enable_rd, lane_enable_wt, lane_enable_fl}), 32'd0);
        chk({name, "_wr"}, 32'({wr_if.wr_lane, wr_if.wr_ch_it, wr_if.wr_src_st, wr_if.wr_dest_st}), 32'd0);
    endtask

    task automatic do_reset();
        tick();
        #2 reset_n = 1'b0;
        #1 check_zero("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic start_job(input logic [NL-1:0] m, input logic [TW-1:0] t);
        lane_mask = m; tmo_limit = t; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_rd(input string name);
        int n = 0;
        while (lane_enable_rd == '0 && n < 20) begin tick(); n++; end
        chk({name, "_rd_seen"}, 32'(lane_enable_rd != '0), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin tick(); n++; end
        chk({name, "_idle"}, 32'(busy), 32'd0);
        tick();
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        wr_if.wr_ready = 1'b1;
        clear_lanes();
        do_reset();

        // start with an empty mask is ignored
        start_job('0, '0);
        chk("empty_mask_busy", 32'(busy), 32'd0);

        // single lane, three writes then done
        clear_lanes(); load(0, 3, 1'b1);
        push(K_SI, 0, 0, 4'b0001); push(K_RD, 0, 0, 4'b0001);
        push(K_WR, 0, 0, '0); push(K_WR, 0, 1, '0); push(K_WR, 0, 2, '0);
        push(K_FL, 0, 0, 4'b0001); push(K_DN, 0, 0, '0);
        start_job(4'b0001, '0);
        wait_idle("single");

        // contention: all lanes valid together
        do_reset();
        clear_lanes();
        for (int i = 0; i < NL; i++) load(i, 1, 1'b1);
        push(K_SI, 0, 0, 4'b1111); push(K_RD, 0, 0, 4'b1111);
        for (int i = 0; i < NL; i++) push(K_WR, i, 0, '0);
        push(K_FL, 0, 0, 4'b1111); push(K_DN, 0, 0, '0);
        start_job(4'b1111, '0);
        wait_idle("contention");

        // backpressure holds lanes 1 and 2 pending
        do_reset();
        clear_lanes(); load(1, 1, 1'b1); load(2, 1, 1'b1);
        wr_if.wr_ready = 1'b0;
        push(K_SI, 0, 0, 4'b0110); push(K_RD, 0, 0, 4'b0110);
        push(K_WR, 1, 0, '0); push(K_WR, 2, 0, '0);
        push(K_FL, 0, 0, 4'b0110); push(K_DN, 0, 0, '0);
        start_job(4'b0110, '0);
        wait_rd("bp");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_no_wr", 32'(wr_if.wr_en), 32'd0);
        end
        chk("bp_wt", 32'(lane_enable_wt), 32'b0110);
        wr_if.wr_ready = 1'b1;
        wait_idle("bp");

        // timeout after 20 RUN cycles
        do_reset();
        clear_lanes(); load(0, 0, 1'b0);
        push(K_SI, 0, 0, 4'b0001); push(K_RD, 0, 0, 4'b0001); push(K_SI, 0, 0, 4'b0001);
        start_job(4'b0001, 16'd20);
        wait_rd("tmo");
        begin
            int n = 0;
            while (lane_set_idle == '0 && n < 100) begin tick(); n++; end
            chk("tmo_cycles", 32'(n), 32'd21);
        end
        chk("tmo_err", 32'(job_err), 32'd1);
        chk("tmo_busy_in_err", 32'(busy), 32'd1);
        wait_idle("tmo");
        chk("tmo_err_sticky", 32'(job_err), 32'd1);

        // abort in a cycle where a grant would otherwise happen
        do_reset();
        clear_lanes(); load(0, 100, 1'b0);
        push(K_SI, 0, 0, 4'b0001); push(K_RD, 0, 0, 4'b0001);
        push(K_WR, 0, 0, '0); push(K_SI, 0, 0, 4'b0001);
        start_job(4'b0001, '0);
        wait_rd("abort");
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_no_wr", 32'(wr_if.wr_en), 32'd0);
        chk("abort_err", 32'(job_err), 32'd1);
        wait_idle("abort");
        chk("abort_err_sticky", 32'(job_err), 32'd1);
        clear_lanes(); load(0, 1, 1'b1);
        push(K_SI, 0, 0, 4'b0001); push(K_RD, 0, 0, 4'b0001);
        push(K_WR, 0, 0, '0); push(K_FL, 0, 0, 4'b0001); push(K_DN, 0, 0, '0);
        start_job(4'b0001, '0);
        chk("restart_clears_err", 32'(job_err), 32'd0);
        wait_idle("restart");

        // reset mid-RUN right after lane 0 was granted
        do_reset();
        clear_lanes(); load(0, 100, 1'b0); load(1, 100, 1'b0);
        push(K_SI, 0, 0, 4'b0011); push(K_RD, 0, 0, 4'b0011); push(K_WR, 0, 0, '0);
        start_job(4'b0011, '0);
        wait_rd("midrst");
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1 check_zero("midrst");
        clear_lanes();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        load(0, 1, 1'b1); load(1, 1, 1'b1);
        push(K_SI, 0, 0, 4'b0011); push(K_RD, 0, 0, 4'b0011);
        push(K_WR, 0, 0, '0); push(K_WR, 1, 0, '0);
        push(K_FL, 0, 0, 4'b0011); push(K_DN, 0, 0, '0);
        start_job(4'b0011, '0);
        wait_idle("postrst");

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
